// File: rtl/mskaes_128bits_rr_arbiter.sv
// Round-robin front end that shares one masked AES-128 core between NREQ
// requesters. Each accepted job pushes its owner index into an in-order tag
// FIFO. Each ciphertext pulse from the core pops the oldest tag and is routed
// back to that owner in the same cycle. Masked buses are only ever selected
// share-wise under public control signals; shares are never combined here.
module mskaes_128bits_rr_arbiter #(
   parameter int  d       = 2,
   parameter int  LATENCY = 4,
   parameter int  NREQ    = 2,
   localparam int TAGW    = (NREQ > 1) ? $clog2(NREQ) : 1,
   localparam int CNTW    = $clog2(LATENCY + 1),
   localparam int SHW     = 128 * d
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*SHW-1:0] req_sh_plaintext,
   input  logic [NREQ*SHW-1:0] req_sh_key,
   output logic [NREQ-1:0]     resp_valid,
   output logic [SHW-1:0]      resp_sh_ciphertext,
   output logic                core_valid_in,
   input  logic                core_ready,
   output logic [SHW-1:0]      core_sh_plaintext,
   output logic [SHW-1:0]      core_sh_key,
   input  logic                core_cipher_valid,
   input  logic [SHW-1:0]      core_sh_ciphertext,
   output logic [CNTW-1:0]     inflight,
   output logic                tag_err
);

   localparam int PTRW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   // Round-robin pointer: index of the most recently granted requester.
   logic [TAGW-1:0] r_ptr;

   // In-order tag FIFO recording the owner of every job inside the core.
   logic [TAGW-1:0] r_tags [LATENCY];
   logic [PTRW-1:0] r_wr_ptr;
   logic [PTRW-1:0] r_rd_ptr;
   logic [CNTW-1:0] r_inflight;
   logic            r_tag_err;

   logic            w_any_valid;
   logic [TAGW-1:0] w_grant;
   logic [NREQ-1:0] w_grant_oh;
   logic            w_fifo_full;
   logic            w_fifo_empty;
   logic            w_issue;
   logic            w_pop;
   logic [TAGW-1:0] w_head;
   logic [NREQ-1:0] w_head_oh;

   // Circular FIFO pointer increment; LATENCY need not be a power of two.
   function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
      return (p == PTRW'(LATENCY - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_any_valid  = |req_valid;
   assign w_fifo_full  = (r_inflight >= CNTW'(LATENCY));
   assign w_fifo_empty = (r_inflight == '0);
   assign w_issue      = ~rst & w_any_valid & core_ready & ~w_fifo_full;
   assign w_pop        = ~rst & core_cipher_valid & ~w_fifo_empty;
   assign w_head       = r_tags[r_rd_ptr];

   // Grant: first valid requester scanning ptr+1, ptr+2, ... modulo NREQ.
   // NOTE: every variable written in an always_comb gets a default first; a
   // path that leaves one unassigned would infer a latch.
   always_comb begin
      w_grant = r_ptr;
      for (int p = 0; p < NREQ; p++) begin
         if (r_ptr == TAGW'(p)) begin
            // Walk from the farthest candidate to the nearest so the nearest
            // valid requester is the last (winning) assignment.
            for (int k = NREQ; k >= 1; k--) begin
               if (req_valid[(p + k) % NREQ]) begin
                  w_grant = TAGW'((p + k) % NREQ);
               end
            end
         end
      end
   end

   // One-hot decode of the granted requester and of the FIFO head tag.
   always_comb begin
      w_grant_oh = '0;
      w_head_oh  = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_grant_oh[i] = (w_grant == TAGW'(i));
         w_head_oh[i]  = (w_head == TAGW'(i));
      end
   end

   // Core-side share-wise mux: forward slice g only while issuing, else zero.
   always_comb begin
      core_sh_plaintext = '0;
      core_sh_key       = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_issue && (w_grant == TAGW'(i))) begin
            core_sh_plaintext = req_sh_plaintext[i*SHW +: SHW];
            core_sh_key       = req_sh_key[i*SHW +: SHW];
         end
      end
   end

   // Response routing: the ciphertext pulse goes to the owner at the FIFO head.
   always_comb begin
      resp_valid         = '0;
      resp_sh_ciphertext = '0;
      if (w_pop) begin
         resp_valid         = w_head_oh;
         resp_sh_ciphertext = core_sh_ciphertext;
      end
   end

   assign req_ready     = w_issue ? w_grant_oh : '0;
   assign core_valid_in = w_issue;
   assign inflight      = r_inflight;
   assign tag_err       = r_tag_err;

   // Control state: rr pointer, FIFO pointers, occupancy and sticky error.
   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr      <= TAGW'(NREQ - 1);
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_inflight <= '0;
         r_tag_err  <= 1'b0;
      end else begin
         if (w_issue) begin
            r_ptr    <= w_grant;
            r_wr_ptr <= ptr_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         if (w_issue && !w_pop) begin
            r_inflight <= r_inflight + 1'b1;
         end else if (!w_issue && w_pop) begin
            r_inflight <= r_inflight - 1'b1;
         end
         if (core_cipher_valid && w_fifo_empty) begin
            r_tag_err <= 1'b1;
         end
      end
   end

   // Tag storage written on issue.
   // NOTE: the tag array is deliberately not reset; an entry is only read
   // while the occupancy count says it holds a live tag.
   always_ff @(posedge clk) begin
      if (w_issue) begin
         r_tags[r_wr_ptr] <= w_grant;
      end
   end

endmodule

// File: tb/tb_mskaes_128bits_rr_arbiter.sv
// Self-checking bench for the round-robin core arbiter. A behavioural core
// model answers jobs in order after a random delay. A request-side model
// predicts every grant from the round-robin rule and pushes the expected
// owner/ciphertext into a scoreboard queue; a separate monitor pops and
// compares whenever the core presents a ciphertext.
module tb_mskaes_128bits_rr_arbiter;

   localparam int D    = 2;
   localparam int LAT  = 4;
   localparam int NREQ = 2;
   localparam int W    = 128 * D;
   localparam int CNTW = $clog2(LAT + 1);

   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [NREQ-1:0]     req_valid = '0;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*W-1:0]   req_sh_plaintext = '0;
   logic [NREQ*W-1:0]   req_sh_key = '0;
   logic [NREQ-1:0]     resp_valid;
   logic [W-1:0]        resp_sh_ciphertext;
   logic                core_valid_in;
   logic                core_ready = 1'b0;
   logic [W-1:0]        core_sh_plaintext;
   logic [W-1:0]        core_sh_key;
   logic                core_cipher_valid = 1'b0;
   logic [W-1:0]        core_sh_ciphertext = '0;
   logic [CNTW-1:0]     inflight;
   logic                tag_err;

   mskaes_128bits_rr_arbiter #(.d(D), .LATENCY(LAT), .NREQ(NREQ)) dut (
      .clk               (clk),
      .rst               (rst),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_sh_plaintext  (req_sh_plaintext),
      .req_sh_key        (req_sh_key),
      .resp_valid        (resp_valid),
      .resp_sh_ciphertext(resp_sh_ciphertext),
      .core_valid_in     (core_valid_in),
      .core_ready        (core_ready),
      .core_sh_plaintext (core_sh_plaintext),
      .core_sh_key       (core_sh_key),
      .core_cipher_valid (core_cipher_valid),
      .core_sh_ciphertext(core_sh_ciphertext),
      .inflight          (inflight),
      .tag_err           (tag_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           owner;
      logic [127:0] ct;
   } exp_t;

   typedef struct {
      logic [127:0] ct;
      longint       due;
   } core_job_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   exp_t        exp_q[$];
   core_job_t   core_q[$];
   longint      cyc = 0;
   longint      last_due = 0;

   // Stimulus controls
   bit          rst_req = 1'b1;
   bit          rand_mode = 1'b0;
   bit          fips_mode = 1'b0;
   bit          core_hold = 1'b0;
   bit          inject_err = 1'b0;
   int          lat_min = 3;
   int          lat_max = 6;
   int          jobs_left [NREQ];
   bit          acc [NREQ];

   // Model state
   int          m_ptr = NREQ - 1;
   bit          m_tag_err = 1'b0;
   bit          pop_now = 1'b0;
   int          n_resp = 0;
   int          n_issue = 0;
   int          gcount [NREQ];
   int          m_g;
   int          m_infl;
   bit          m_issue;
   logic [NREQ-1:0] m_exp_ready;
   logic [W-1:0]    m_exp_pt;
   logic [W-1:0]    m_exp_key;
   exp_t            mon_e;
   core_job_t       cj;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] recombine(input logic [W-1:0] s);
      logic [127:0] r = '0;
      for (int k = 0; k < D; k++) r ^= s[k*128 +: 128];
      return r;
   endfunction

   function automatic logic [W-1:0] share(input logic [127:0] v);
      logic [W-1:0] s;
      logic [127:0] r = v;
      logic [127:0] m;
      for (int k = 1; k < D; k++) begin
         m = {$urandom, $urandom, $urandom, $urandom};
         s[k*128 +: 128] = m;
         r ^= m;
      end
      s[127:0] = r;
      return s;
   endfunction

   // Stand-in for the cipher: exact on the FIPS-197 vector, a keyed mix otherwise.
   function automatic logic [127:0] fake_core(input logic [127:0] pt, input logic [127:0] key);
      if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
      return pt ^ {key[63:0], key[127:64]} ^ 128'h5a5a_0f0f_a5a5_f0f0_3c3c_c3c3_9696_6969;
   endfunction

   task automatic new_job(input int i);
      logic [127:0] pt;
      logic [127:0] key;
      pt  = (fips_mode && i == 0) ? FIPS_PT  : {$urandom, $urandom, $urandom, $urandom};
      key = (fips_mode && i == 0) ? FIPS_KEY : {$urandom, $urandom, $urandom, $urandom};
      req_sh_plaintext[i*W +: W] = share(pt);
      req_sh_key[i*W +: W]       = share(key);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // One stimulus cycle: requesters keep data stable until accepted, the core
   // model emits its oldest due ciphertext.
   task automatic drive_cycle();
      @(posedge clk);
      #1;
      rst = rst_req;
      for (int i = 0; i < NREQ; i++) begin
         if (!(req_valid[i] && !acc[i] && !(rand_mode && $urandom_range(0, 7) == 0))) begin
            if (rand_mode) begin
               req_valid[i] = ($urandom_range(0, 2) != 0);
            end else if (jobs_left[i] != 0) begin
               req_valid[i] = 1'b1;
               if (jobs_left[i] > 0) jobs_left[i]--;
            end else begin
               req_valid[i] = 1'b0;
            end
            new_job(i);
         end
      end
      core_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!rst && !core_hold && core_q.size() != 0 && core_q[0].due <= cyc) begin
         core_cipher_valid  = 1'b1;
         core_sh_ciphertext = share(core_q[0].ct);
         void'(core_q.pop_front());
      end else if (!rst && inject_err && core_q.size() == 0) begin
         core_cipher_valid  = 1'b1;
         core_sh_ciphertext = share({$urandom, $urandom, $urandom, $urandom});
         inject_err         = 1'b0;
      end else begin
         core_cipher_valid  = 1'b0;
         core_sh_ciphertext = share({$urandom, $urandom, $urandom, $urandom});
      end
   endtask

   task automatic cycles(input int n);
      for (int c = 0; c < n; c++) drive_cycle();
   endtask

   task automatic do_reset(input int n);
      rst_req = 1'b1;
      cycles(n);
      rst_req = 1'b0;
      drive_cycle();
   endtask

   task automatic drain(input string name, input int max_cycles);
      int n = 0;
      for (int i = 0; i < NREQ; i++) jobs_left[i] = 0;
      rand_mode = 1'b0;
      core_hold = 1'b0;
      while ((exp_q.size() != 0 || core_q.size() != 0 || req_valid != '0) && n < max_cycles) begin
         drive_cycle();
         n++;
      end
      check(name, exp_q.size(), 0);
   endtask

   // Core model: accepts a job on valid_in and schedules its in-order answer.
   always @(negedge clk) begin
      #3;
      if (rst) begin
         core_q.delete();
         last_due = 0;
      end else if (core_valid_in && core_ready) begin
         cj.ct  = fake_core(recombine(core_sh_plaintext), recombine(core_sh_key));
         cj.due = cyc + longint'($urandom_range(lat_min, lat_max));
         if (cj.due <= last_due) cj.due = last_due + 1;
         last_due = cj.due;
         core_q.push_back(cj);
      end
   end

   // Monitor: compares the response side against the scoreboard head.
   always @(negedge clk) begin
      pop_now = 1'b0;
      check("inflight", inflight, exp_q.size());
      check("tag_err", tag_err, m_tag_err);
      if (rst) begin
         check("resp_valid_rst", resp_valid, 0);
      end else if (core_cipher_valid || resp_valid != '0) begin
         if (exp_q.size() != 0) begin
            mon_e   = exp_q.pop_front();
            pop_now = 1'b1;
            n_resp++;
            check("resp_owner", resp_valid, NREQ'(1) << mon_e.owner);
            check("resp_ct", recombine(resp_sh_ciphertext), mon_e.ct);
         end else begin
            check("resp_valid_empty", resp_valid, 0);
            check("resp_ct_empty", resp_sh_ciphertext, 0);
            m_tag_err = 1'b1;
         end
      end else begin
         check("resp_idle", resp_valid, 0);
         check("resp_ct_idle", resp_sh_ciphertext, 0);
      end
   end

   // Request-side model: round-robin rule on the current requests.
   always @(negedge clk) begin
      #2;
      m_infl  = exp_q.size() + int'(pop_now);
      m_g     = -1;
      m_issue = 1'b0;
      if (!rst) begin
         for (int k = 1; k <= NREQ; k++) begin
            if (m_g < 0 && req_valid[(m_ptr + k) % NREQ]) m_g = (m_ptr + k) % NREQ;
         end
         m_issue = (m_g >= 0) && core_ready && (m_infl < LAT);
      end
      m_exp_ready = '0;
      m_exp_pt    = '0;
      m_exp_key   = '0;
      if (m_issue) begin
         m_exp_ready[m_g] = 1'b1;
         m_exp_pt         = req_sh_plaintext[m_g*W +: W];
         m_exp_key        = req_sh_key[m_g*W +: W];
      end
      check("req_ready", req_ready, m_exp_ready);
      check("core_valid_in", core_valid_in, m_issue);
      check("core_pt", core_sh_plaintext, m_exp_pt);
      check("core_key", core_sh_key, m_exp_key);
      for (int i = 0; i < NREQ; i++) acc[i] = req_ready[i];
      if (m_issue) begin
         exp_q.push_back('{owner: m_g, ct: fake_core(recombine(m_exp_pt), recombine(m_exp_key))});
         m_ptr = m_g;
         n_issue++;
         gcount[m_g]++;
      end
      if (rst) begin
         exp_q.delete();
         m_ptr     = NREQ - 1;
         m_tag_err = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base_resp;
      int base_issue;
      int diff;
      for (int i = 0; i < NREQ; i++) begin
         jobs_left[i] = 0;
         acc[i]       = 1'b0;
         gcount[i]    = 0;
      end
      do_reset(3);
      check("reset_inflight", inflight, 0);

      // FIPS-197 vector from requester 0 alone
      fips_mode    = 1'b1;
      jobs_left[0] = 1;
      base_resp    = n_resp;
      base_issue   = n_issue;
      cycles(20);
      check("t1_grants", n_issue - base_issue, 1);
      check("t1_responses", n_resp - base_resp, 1);
      fips_mode = 1'b0;
      drain("t1_drain", 50);

      // Both requesters continuously valid: grants alternate
      for (int i = 0; i < NREQ; i++) gcount[i] = 0;
      jobs_left[0] = -1;
      jobs_left[1] = -1;
      cycles(40);
      diff = gcount[0] - gcount[1];
      check("t2_fairness", (diff >= -1 && diff <= 1), 1);
      drain("t2_drain", 60);

      // Core answers held off: issue stops at LATENCY jobs in flight
      core_hold    = 1'b1;
      jobs_left[0] = -1;
      jobs_left[1] = -1;
      cycles(8);
      check("t3_full", inflight, LAT);
      check("t3_blocked", core_valid_in, 0);
      core_hold = 1'b0;
      cycles(12);
      drain("t3_drain", 60);

      // Reset with three jobs in flight discards them
      core_hold    = 1'b1;
      jobs_left[1] = 3;
      cycles(6);
      check("t5_inflight", inflight, 3);
      do_reset(1);
      check("t5_cleared", inflight, 0);
      core_hold    = 1'b0;
      jobs_left[0] = 1;
      jobs_left[1] = 1;
      cycles(10);
      drain("t5_drain", 60);

      // Ciphertext with nothing in flight raises a sticky error
      inject_err = 1'b1;
      cycles(5);
      check("t6_sticky", tag_err, 1);
      do_reset(2);
      check("t6_cleared", tag_err, 0);

      // Randomised traffic with random core latency
      lat_min   = 1;
      lat_max   = 10;
      rand_mode = 1'b1;
      cycles(400);
      drain("random_drain", 200);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
